// File: rtl/tmip_result_collector.sv
// tmip_result_collector
//   Receive side of the TMIP serial result port. Deserialises out_valid/out_value
//   (MSB first) into WORD_W-bit words and marks the final word of each frame
//   (a gap in out_valid after a word ends the frame). Words are queued in a
//   DEPTH-entry FIFO and presented on a valid/ready interface.
//
// Ports
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   out_valid     : serial bit valid from TMIP
//   out_value     : serial bit, MSB of each word first
//   word_valid    : FIFO head holds a word
//   word_data     : FIFO head word
//   word_last     : FIFO head is the last word of its frame
//   word_ready    : consumer accepts the head this cycle
//   frame_words   : word count of the most recently completed frame
//   frame_done    : one-cycle pulse after the last word of a frame is pushed
//   err_partial   : one-cycle pulse, out_valid fell mid-word
//   err_overflow  : one-cycle pulse, a word was dropped on a full FIFO
module tmip_result_collector #(
    parameter int WORD_W = 20,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              out_valid,
    input  logic              out_value,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              word_last,
    input  logic              word_ready,
    output logic [CNT_W-1:0]  frame_words,
    output logic              frame_done,
    output logic              err_partial,
    output logic              err_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int BIT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // shift stage
    logic [WORD_W-1:0] shreg;
    logic [BIT_W-1:0]  bitcnt;

    // hold stage
    logic              hold_v;
    logic [WORD_W-1:0] hold_data;

    // FIFO storage
    logic [WORD_W-1:0] mem_data [DEPTH];
    logic              mem_last [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    // frame counter
    logic [CNT_W-1:0]  fcnt;
    logic [CNT_W-1:0]  fcnt_inc;

    logic word_complete;
    logic push;
    logic push_last;
    logic pop;
    logic full;
    logic do_write;

    assign word_valid = (count != '0);
    assign word_data  = mem_data[rd_ptr];
    assign word_last  = mem_last[rd_ptr];

    always_comb begin
        word_complete = out_valid && (bitcnt == BIT_W'(WORD_W - 1));
        push          = hold_v;
        // The bit stream continuing right after a word means the frame goes on.
        push_last     = !out_valid;
        pop           = word_valid && word_ready;
        full          = (count == (PTR_W+1)'(DEPTH));
        // A pop in the same edge frees the slot the push lands in.
        do_write      = push && (!full || pop);
        fcnt_inc      = (fcnt == CNT_MAX) ? fcnt : fcnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg        <= '0;
            bitcnt       <= '0;
            hold_v       <= 1'b0;
            hold_data    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            fcnt         <= '0;
            frame_words  <= '0;
            frame_done   <= 1'b0;
            err_partial  <= 1'b0;
            err_overflow <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
        end else begin
            frame_done   <= 1'b0;
            err_partial  <= 1'b0;
            err_overflow <= 1'b0;

            // Shift stage
            if (out_valid) begin
                shreg <= {shreg[WORD_W-2:0], out_value};
                if (word_complete) begin
                    bitcnt <= '0;
                end else begin
                    bitcnt <= bitcnt + BIT_W'(1);
                end
            end else if (bitcnt != '0) begin
                shreg       <= '0;
                bitcnt      <= '0;
                err_partial <= 1'b1;
            end

            // Hold stage: one-edge buffer so the last flag can look at the
            // following edge's out_valid.
            hold_v <= word_complete;
            if (word_complete) begin
                hold_data <= {shreg[WORD_W-2:0], out_value};
            end

            // FIFO write / overflow
            if (do_write) begin
                mem_data[wr_ptr] <= hold_data;
                mem_last[wr_ptr] <= push_last;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (push && !do_write) begin
                err_overflow <= 1'b1;
            end

            // FIFO read
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({do_write, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase

            // Frame counter counts dropped words too; a dropped last word
            // still closes the frame.
            if (push) begin
                if (push_last) begin
                    frame_words <= fcnt_inc;
                    fcnt        <= '0;
                    frame_done  <= 1'b1;
                end else begin
                    fcnt <= fcnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_tmip_result_collector.sv
module tb_tmip_result_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_valid = 1'b0;
    logic        out_value = 1'b0;
    logic        word_ready = 1'b1;
    logic        word_valid;
    logic [19:0] word_data;
    logic        word_last;
    logic [8:0]  frame_words;
    logic        frame_done;
    logic        err_partial;
    logic        err_overflow;

    int errors = 0;
    int checks = 0;

    int          n_done = 0;
    int          n_part = 0;
    int          n_ovf  = 0;
    logic [20:0] rx_q [$];
    logic [8:0]  fw_q [$];

    tmip_result_collector #(
        .WORD_W(20),
        .DEPTH (4),
        .CNT_W (9)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .out_valid   (out_valid),
        .out_value   (out_value),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .word_last   (word_last),
        .word_ready  (word_ready),
        .frame_words (frame_words),
        .frame_done  (frame_done),
        .err_partial (err_partial),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    // Record handshakes and pulses mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid && word_ready) rx_q.push_back({word_last, word_data});
            if (frame_done) begin
                n_done++;
                fw_q.push_back(frame_words);
            end
            if (err_partial)  n_part++;
            if (err_overflow) n_ovf++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rx(input string tag, input int idx, input logic [20:0] exp);
        logic [20:0] obs;
        obs = (idx < rx_q.size()) ? rx_q[idx] : 21'bx;
        check(tag, {11'b0, obs}, {11'b0, exp});
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        out_valid = 1'b1;
        out_value = b;
        cyc(1);
    endtask

    task automatic send_word(input logic [19:0] w);
        for (int i = 19; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic gap(input int n);
        out_valid = 1'b0;
        out_value = 1'b0;
        cyc(n);
    endtask

    task automatic clear_log;
        rx_q.delete();
        fw_q.delete();
        n_done = 0;
        n_part = 0;
        n_ovf  = 0;
    endtask

    initial begin
        // Reset state
        cyc(2);
        check("rst_valid", word_valid, 0);
        check("rst_data", word_data, 0);
        check("rst_last", word_last, 0);
        check("rst_fwords", frame_words, 0);
        check("rst_pulses", {frame_done, err_partial, err_overflow}, 0);
        rst = 1'b0;
        cyc(1);

        // Single-word frame 0xA5A5F
        clear_log();
        send_word(20'hA5A5F);
        out_valid = 1'b0;
        out_value = 1'b0;
        check("t1_not_yet", word_valid, 0);
        cyc(1);
        check("t1_valid", word_valid, 1);
        check("t1_data", word_data, 20'hA5A5F);
        check("t1_last", word_last, 1);
        check("t1_done", frame_done, 1);
        check("t1_fwords", frame_words, 1);
        cyc(1);
        check("t1_valid_gone", word_valid, 0);
        check("t1_done_gone", frame_done, 0);
        gap(3);
        check("t1_nerr", n_part + n_ovf, 0);

        // Continuous 16-word frame
        clear_log();
        for (int v = 0; v < 16; v++) send_word(20'(v));
        gap(5);
        check("t2_count", rx_q.size(), 16);
        for (int i = 0; i < 16; i++)
            check_rx($sformatf("t2_word%0d", i), i, {(i == 15) ? 1'b1 : 1'b0, 20'(i)});
        check("t2_fwords", frame_words, 16);
        check("t2_ndone", n_done, 1);
        check("t2_nerr", n_part + n_ovf, 0);

        // Partial word, then a full single word
        clear_log();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        gap(1);
        send_word(20'h00001);
        gap(4);
        check("t3_npart", n_part, 1);
        check("t3_count", rx_q.size(), 1);
        check_rx("t3_word", 0, {1'b1, 20'h00001});
        check("t3_fwords", frame_words, 1);

        // Overflow: 6-word frame into a 4-deep FIFO with no consumer
        clear_log();
        word_ready = 1'b0;
        for (int v = 0; v < 6; v++) send_word(20'(v));
        gap(3);
        check("t4_novf", n_ovf, 2);
        check("t4_fwords", frame_words, 6);
        check("t4_valid", word_valid, 1);
        check("t4_head", {word_last, word_data}, {1'b0, 20'h00000});
        cyc(2);
        check("t4_head_stable", {word_last, word_data}, {1'b0, 20'h00000});
        word_ready = 1'b1;
        cyc(6);
        check("t4_count", rx_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check_rx($sformatf("t4_word%0d", i), i, {1'b0, 20'(i)});
        check("t4_empty", word_valid, 0);

        // Two frames with a one-cycle gap, ready toggling every cycle
        clear_log();
        fork
            begin
                repeat (120) begin
                    word_ready = ~word_ready;
                    cyc(1);
                end
            end
            begin
                send_word(20'd10);
                send_word(20'd11);
                send_word(20'd12);
                gap(1);
                send_word(20'd13);
                send_word(20'd14);
                gap(6);
            end
        join
        word_ready = 1'b1;
        cyc(2);
        check("t5_count", rx_q.size(), 5);
        check_rx("t5_w0", 0, {1'b0, 20'd10});
        check_rx("t5_w1", 1, {1'b0, 20'd11});
        check_rx("t5_w2", 2, {1'b1, 20'd12});
        check_rx("t5_w3", 3, {1'b0, 20'd13});
        check_rx("t5_w4", 4, {1'b1, 20'd14});
        check("t5_nframes", fw_q.size(), 2);
        check("t5_fw0", (fw_q.size() > 0) ? fw_q[0] : 9'bx, 3);
        check("t5_fw1", (fw_q.size() > 1) ? fw_q[1] : 9'bx, 2);
        check("t5_nerr", n_part + n_ovf, 0);

        // Reset mid-word, mid-frame, with two words queued
        clear_log();
        word_ready = 1'b0;
        send_word(20'h11111);
        send_word(20'h22222);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        check("t6_pre_valid", word_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", word_valid, 0);
        check("t6_rst_data", {word_last, word_data}, 0);
        check("t6_rst_fwords", frame_words, 0);
        check("t6_rst_pulses", {frame_done, err_partial, err_overflow}, 0);
        cyc(2);
        out_valid = 1'b0;
        out_value = 1'b0;
        word_ready = 1'b1;
        rst = 1'b0;
        cyc(2);
        check("t6_post_valid", word_valid, 0);
        send_word(20'h12345);
        send_word(20'hFEDCB);
        gap(4);
        check("t6_count", rx_q.size(), 2);
        check_rx("t6_w0", 0, {1'b0, 20'h12345});
        check_rx("t6_w1", 1, {1'b1, 20'hFEDCB});
        check("t6_fwords", frame_words, 2);
        check("t6_ndone", n_done, 1);
        check("t6_nerr", n_part + n_ovf, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
